// File: rtl/jtpopeye_clk_pkg.sv
// Shared types and defaults for the Popeye clock-enable / reset block.
//   state_t   : sequencer states (WAIT_LOCK -> HOLD -> RUN)
//   *_DEF     : default enable ratios and timing constants for a 40 MHz clock
//   acc_w()   : accumulator width for a fractional divider of denominator den
package jtpopeye_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int CPU_NUM_DEF     = 1;
  localparam int CPU_DEN_DEF     = 10;
  localparam int PXL_NUM_DEF     = 63;
  localparam int PXL_DEN_DEF     = 250;
  localparam int SND_NUM_DEF     = 3;
  localparam int SND_DEN_DEF     = 80;
  localparam int HOLD_CYCLES_DEF = 4000;
  localparam int LOCK_FILT_DEF   = 16;

  // One extra bit so acc+NUM (< 2*DEN) never overflows.
  function automatic int acc_w(input int den);
    return $clog2(den) + 1;
  endfunction

endpackage

// File: rtl/jtpopeye_frac_cen.sv
// Fractional clock enable: NUM pulses every DEN clocks, one clk wide.
//   clk : clock
//   rst : synchronous active-high reset
//   en  : run the accumulator; low holds it (and cen) at zero
//   cen : registered enable pulse
module jtpopeye_frac_cen
  import jtpopeye_clk_pkg::*;
#(
  parameter int NUM = 1,
  parameter int DEN = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic cen
);

  localparam int W = acc_w(DEN);

  if (NUM <= 0 || NUM > DEN) begin : g_bad_ratio
    $error("jtpopeye_frac_cen: NUM must satisfy 0 < NUM <= DEN");
  end

  logic [W-1:0] acc;
  logic [W-1:0] sum;

  assign sum = acc + W'(NUM);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (sum >= W'(DEN)) begin
      acc <= sum - W'(DEN);
      cen <= 1'b1;
    end else begin
      acc <= sum;
      cen <= 1'b0;
    end
  end

endmodule

// File: rtl/jtpopeye_cen_rst.sv
// Game reset and clock-enable generator sitting between the PLL and the core.
// Waits for a filtered PLL lock, holds the core in reset for HOLD_CYCLES
// (SDRAM power-up) while the enables already run, then releases reset.
// Any loss of lock drops straight back to WAIT_LOCK.
//   clk        : 40 MHz game clock
//   rst        : synchronous active-high board reset
//   pll_locked : PLL lock flag, asynchronous to clk
//   cen_stall  : (JTPOPEYE_CEN_STALL_EN only) suppress cen_cpu while in RUN
//   rst_game   : registered active-high reset to the game core
//   cen_cpu    : CPU enable   (CPU_NUM/CPU_DEN)
//   cen_pxl    : pixel enable (PXL_NUM/PXL_DEN)
//   cen_snd    : sound enable (SND_NUM/SND_DEN)
//   running    : high while in RUN
// Optional feature macro: JTPOPEYE_CEN_STALL_EN
module jtpopeye_cen_rst
  import jtpopeye_clk_pkg::*;
#(
  parameter int CPU_NUM     = CPU_NUM_DEF,
  parameter int CPU_DEN     = CPU_DEN_DEF,
  parameter int PXL_NUM     = PXL_NUM_DEF,
  parameter int PXL_DEN     = PXL_DEN_DEF,
  parameter int SND_NUM     = SND_NUM_DEF,
  parameter int SND_DEN     = SND_DEN_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int LOCK_FILT   = LOCK_FILT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
`ifdef JTPOPEYE_CEN_STALL_EN
  input  logic cen_stall,
`endif
  output logic rst_game,
  output logic cen_cpu,
  output logic cen_pxl,
  output logic cen_snd,
  output logic running
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [1:0]    lock_sync;
  logic          lock_s;
  logic [FW-1:0] filt_cnt;
  logic          lock_ok;
  state_t        st;
  logic [HW-1:0] hold_cnt;
  logic          cen_en;
  logic          cpu_raw;

  // Two-flop synchroniser, then a saturating run-length filter.
  assign lock_s = lock_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      filt_cnt  <= '0;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      if (!lock_s)
        filt_cnt <= '0;
      else if (filt_cnt != FW'(LOCK_FILT))
        filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Gated by lock_s so a low sample kills lock_ok immediately.
  assign lock_ok = lock_s && (filt_cnt == FW'(LOCK_FILT));

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= WAIT_LOCK;
      hold_cnt <= '0;
      rst_game <= 1'b1;
      running  <= 1'b0;
    end else begin
      case (st)
        WAIT_LOCK: begin
          if (lock_ok) begin
            st       <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!lock_ok) begin
            st <= WAIT_LOCK;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            st       <= RUN;
            rst_game <= 1'b0;
            running  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_ok) begin
            st       <= WAIT_LOCK;
            rst_game <= 1'b1;
            running  <= 1'b0;
          end
        end
        default: begin
          st       <= WAIT_LOCK;
          rst_game <= 1'b1;
          running  <= 1'b0;
        end
      endcase
    end
  end

  // Including lock_ok means the enables stop on the same edge the FSM
  // falls back to WAIT_LOCK, instead of one clk later.
  assign cen_en = (st != WAIT_LOCK) && lock_ok;

  jtpopeye_frac_cen #(.NUM(CPU_NUM), .DEN(CPU_DEN)) u_cpu (
    .clk(clk), .rst(rst), .en(cen_en), .cen(cpu_raw)
  );

  jtpopeye_frac_cen #(.NUM(PXL_NUM), .DEN(PXL_DEN)) u_pxl (
    .clk(clk), .rst(rst), .en(cen_en), .cen(cen_pxl)
  );

  jtpopeye_frac_cen #(.NUM(SND_NUM), .DEN(SND_DEN)) u_snd (
    .clk(clk), .rst(rst), .en(cen_en), .cen(cen_snd)
  );

`ifdef JTPOPEYE_CEN_STALL_EN
  // One-deep memory of a CPU pulse swallowed by the stall; several
  // swallowed pulses collapse into the single catch-up pulse.
  logic cpu_pend;

  always_ff @(posedge clk) begin
    if (rst || !running)
      cpu_pend <= 1'b0;
    else if (cen_stall) begin
      if (cpu_raw) cpu_pend <= 1'b1;
    end else
      cpu_pend <= 1'b0;
  end

  assign cen_cpu = (running && cen_stall) ? 1'b0 : (cpu_raw | cpu_pend);
`else
  assign cen_cpu = cpu_raw;
`endif

endmodule

// File: tb/tb_jtpopeye_cen_rst.sv
// Bench for jtpopeye_cen_rst: reset/lock sequencing, enable cadence and
// ratios, lock glitch recovery, reset-vs-lock-loss, lock filter rejection,
// and (with JTPOPEYE_CEN_STALL_EN) the CPU enable stall.
module tb_jtpopeye_cen_rst;

  localparam int CPU_NUM = 1,  CPU_DEN = 10;
  localparam int PXL_NUM = 63, PXL_DEN = 250;
  localparam int SND_NUM = 3,  SND_DEN = 80;
  localparam int HOLD    = 4000;
  localparam int LF      = 16;

  logic clk = 1'b0;
  logic rst, pll_locked;
  logic rst_game, cen_cpu, cen_pxl, cen_snd, running;
`ifdef JTPOPEYE_CEN_STALL_EN
  logic cen_stall;
  logic d_stall;
`endif
  logic d_rst, d_lock;

  int nerr = 0;
  int nchk = 0;
  int cpu_q[$];
  int pxl_q[$];
  int snd_q[$];
  int last_pxl = 0;

  always #5 clk = ~clk;

  jtpopeye_cen_rst #(
    .CPU_NUM(CPU_NUM), .CPU_DEN(CPU_DEN),
    .PXL_NUM(PXL_NUM), .PXL_DEN(PXL_DEN),
    .SND_NUM(SND_NUM), .SND_DEN(SND_DEN),
    .HOLD_CYCLES(HOLD), .LOCK_FILT(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
`ifdef JTPOPEYE_CEN_STALL_EN
    .cen_stall(cen_stall),
`endif
    .rst_game(rst_game),
    .cen_cpu(cen_cpu),
    .cen_pxl(cen_pxl),
    .cen_snd(cen_snd),
    .running(running)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pass one rising edge, drive the next inputs just after it, sample on
  // the falling edge. Inputs driven here reach the DUT flops on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    rst        = d_rst;
    pll_locked = d_lock;
`ifdef JTPOPEYE_CEN_STALL_EN
    cen_stall  = d_stall;
`endif
    @(negedge clk);
  endtask

  // Scoreboard: pop expected pulse times as enables appear.
  task automatic track(input int n);
    if (cen_cpu) begin
      if (cpu_q.size() > 0) chk("cpu_time", n, cpu_q.pop_front());
      cpu_q.push_back(n + CPU_DEN);
    end
    if (cen_pxl) begin
      if (pxl_q.size() > 0) chk("pxl_first", n, pxl_q.pop_front());
      else chk("pxl_gap3or4", int'((n - last_pxl) == 3 || (n - last_pxl) == 4), 1);
      last_pxl = n;
    end
    if (cen_snd && snd_q.size() > 0) chk("snd_first", n, snd_q.pop_front());
  endtask

  initial begin
    int rel, early, ncpu, npxl, nsnd, viol;
    rst = 1'b1; pll_locked = 1'b1;
    d_rst = 1'b1; d_lock = 1'b1;
`ifdef JTPOPEYE_CEN_STALL_EN
    cen_stall = 1'b0; d_stall = 1'b0;
`endif
    repeat (5) step();
    chk("rst_rst_game", int'(rst_game), 1);
    chk("rst_running",  int'(running),  0);
    chk("rst_cen_cpu",  int'(cen_cpu),  0);
    chk("rst_cen_pxl",  int'(cen_pxl),  0);
    chk("rst_cen_snd",  int'(cen_snd),  0);

    // HOLD is entered on edge 3+LF; first pulse ceil(DEN/NUM) clks later.
    cpu_q.push_back(3 + LF + (CPU_DEN + CPU_NUM - 1) / CPU_NUM);
    pxl_q.push_back(3 + LF + (PXL_DEN + PXL_NUM - 1) / PXL_NUM);
    snd_q.push_back(3 + LF + (SND_DEN + SND_NUM - 1) / SND_NUM);

    d_rst = 1'b0;
    step();
    rel = -1; early = 0;
    for (int n = 1; n <= 3 + LF + HOLD + 100; n++) begin
      step();
      if (n <= 3 + LF && (cen_cpu || cen_pxl || cen_snd)) early++;
      track(n);
      if (!rst_game) begin rel = n; break; end
    end
    chk("no_cen_before_lock", early, 0);
    chk("release_edge", rel, 2 + LF + HOLD + 1);
    chk("running_at_release", int'(running), 1);

    // Cadence in RUN: 2000 clks is a whole number of periods for all three.
    ncpu = 0; npxl = 0; nsnd = 0;
    for (int n = rel + 1; n <= rel + 2000; n++) begin
      step();
      track(n);
      ncpu += int'(cen_cpu);
      npxl += int'(cen_pxl);
      nsnd += int'(cen_snd);
    end
    chk("cpu_count_2000", ncpu, 2000 * CPU_NUM / CPU_DEN);
    chk("pxl_count_2000", npxl, 2000 * PXL_NUM / PXL_DEN);
    chk("snd_count_2000", nsnd, 2000 * SND_NUM / SND_DEN);

    // 250-clk pixel window; with the stall feature a 25-clk stall sits inside.
    npxl = 0; ncpu = 0; viol = 0;
    for (int i = 0; i < 250; i++) begin
`ifdef JTPOPEYE_CEN_STALL_EN
      d_stall = (i >= 100 && i < 125);
`endif
      step();
      npxl += int'(cen_pxl);
      ncpu += int'(cen_cpu);
`ifdef JTPOPEYE_CEN_STALL_EN
      if (i >= 100 && i < 125 && cen_cpu) viol++;
      if (i == 125) chk("stall_release_pulse", int'(cen_cpu), 1);
`endif
    end
    chk("pxl_count_250", npxl, PXL_NUM);
`ifdef JTPOPEYE_CEN_STALL_EN
    chk("cpu_during_stall", viol, 0);
`else
    chk("cpu_count_250", ncpu, 250 * CPU_NUM / CPU_DEN);
`endif

    // One-clk lock glitch in RUN.
    d_lock = 1'b0;
    step();
    d_lock = 1'b1;
    rel = -1; early = 0;
    for (int n = 1; n <= 20 + HOLD + 100; n++) begin
      step();
      if (n == 3) begin
        chk("glitch_rst_game", int'(rst_game), 1);
        chk("glitch_running",  int'(running),  0);
        chk("glitch_cens", int'(cen_cpu) + int'(cen_pxl) + int'(cen_snd), 0);
      end
      if (n >= 3 && n <= 20 && (cen_cpu || cen_pxl || cen_snd)) early++;
      if (n > 3 && !rst_game) begin rel = n; break; end
    end
    chk("glitch_no_cen_relock", early, 0);
    chk("glitch_release_edge", rel, 20 + HOLD);
    chk("glitch_running_again", int'(running), 1);

    // Reset together with lock loss behaves as plain reset.
    d_rst = 1'b1; d_lock = 1'b0;
    repeat (4) step();
    chk("rstlock_rst_game", int'(rst_game), 1);
    chk("rstlock_running",  int'(running),  0);
    chk("rstlock_cens", int'(cen_cpu) + int'(cen_pxl) + int'(cen_snd), 0);

    // Lock toggling every 8 clks never satisfies the 16-clk filter.
    d_rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 320; i++) begin
      d_lock = ((i / 8) % 2) == 0;
      step();
      if (running || !rst_game || cen_cpu || cen_pxl || cen_snd) viol++;
    end
    chk("filter_reject", viol, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
